ram_dp_be: RTL and testbench

Parametrised true dual-port synchronous RAM with per-byte write enables, a selectable same-port read-during-write mode, and a post-reset clear sequencer. It succeeds the single-port 8-bit scratch RAM used in the processor datapath. Two independent requesters, e.g. instruction fetch and load/store, can share one array. The array itself is never reset, so the block maps to block RAM; zeroing is done by an internal FSM after reset.

---
 rtl/ram_dp_be_if.sv | 30 +++
 rtl/ram_dp_be.sv | 111 +++++++++++
 tb/tb_ram_dp_be.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ram_dp_be_if.sv
// Bus bundle for the two independent ports of ram_dp_be.
// Requesters use the master view and the RAM uses the slave view.
interface ram_dp_be_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 256,
    parameter int BYTE_W = 8
);
    localparam int NB = WIDTH / BYTE_W;
    localparam int AW = $clog2(DEPTH);

    logic             a_en,    b_en;
    logic             a_we,    b_we;
    logic [NB-1:0]    a_be,    b_be;
    logic [AW-1:0]    a_addr,  b_addr;
    logic [WIDTH-1:0] a_wdata, b_wdata;
    logic [WIDTH-1:0] a_rdata, b_rdata;
    logic             a_rvalid, b_rvalid;

    modport master (
        output a_en, a_we, a_be, a_addr, a_wdata,
        output b_en, b_we, b_be, b_addr, b_wdata,
        input  a_rdata, a_rvalid, b_rdata, b_rvalid
    );

    modport slave (
        input  a_en, a_we, a_be, a_addr, a_wdata,
        input  b_en, b_we, b_be, b_addr, b_wdata,
        output a_rdata, a_rvalid, b_rdata, b_rvalid
    );
endinterface

// File: rtl/ram_dp_be.sv
// True dual-port RAM with byte-lane write enables and a post-reset clear
// sequencer; the array is left unreset so it can map onto block RAM.
module ram_dp_be #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 256,
    parameter int BYTE_W     = 8,
    parameter int RD_MODE    = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          init_busy,
    ram_dp_be_if.slave    bus
);
    localparam int NB = WIDTH / BYTE_W;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_t;

    state_t           state, state_nx;
    logic [AW-1:0]    clr_cnt;
    logic             clr_we;
    logic             a_acc, b_acc;
    logic [NB-1:0]    a_wr, b_wr;
    logic [WIDTH-1:0] a_old, b_old, a_merged, b_merged;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RESET;
        else     state <= state_nx;
    end

    // The first clear write (address 0) happens on the edge that leaves
    // RESET, so the whole clear spans exactly DEPTH edges after release.
    always_comb begin
        state_nx = state;
        case (state)
            ST_RESET: state_nx = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
            ST_CLEAR: if (clr_cnt == AW'(DEPTH - 1)) state_nx = ST_READY;
            default:  state_nx = ST_READY;
        endcase
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        init_busy = 1'b0;
        clr_we    = 1'b0;
        case (state)
            ST_RESET: begin
                init_busy = (INIT_CLEAR != 0);
                clr_we    = (INIT_CLEAR != 0);
            end
            ST_CLEAR: begin
                init_busy = 1'b1;
                clr_we    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         clr_cnt <= '0;
        else if (clr_we) clr_cnt <= clr_cnt + 1'b1;
    end

    assign a_acc = bus.a_en && !init_busy;
    assign b_acc = bus.b_en && !init_busy;
    assign a_old = mem[bus.a_addr];
    assign b_old = mem[bus.b_addr];

    // Each port's write-first view only merges its own lanes.
    always_comb begin
        a_merged = a_old;
        b_merged = b_old;
        for (int i = 0; i < NB; i++) begin
            a_wr[i] = a_acc && bus.a_we && bus.a_be[i];
            b_wr[i] = b_acc && bus.b_we && bus.b_be[i];
            if (a_wr[i]) a_merged[i*BYTE_W +: BYTE_W] = bus.a_wdata[i*BYTE_W +: BYTE_W];
            if (b_wr[i]) b_merged[i*BYTE_W +: BYTE_W] = bus.b_wdata[i*BYTE_W +: BYTE_W];
        end
    end

    // NOTE: the array has no reset on purpose; a reset term would stop it
    // mapping onto block RAM. Zeroing is the clear sequencer's job.
    // Port A is written after port B so A wins lanes both ports enable.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (b_wr[i]) mem[bus.b_addr][i*BYTE_W +: BYTE_W] <= bus.b_wdata[i*BYTE_W +: BYTE_W];
                if (a_wr[i]) mem[bus.a_addr][i*BYTE_W +: BYTE_W] <= bus.a_wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.a_rdata  <= '0;
            bus.b_rdata  <= '0;
            bus.a_rvalid <= 1'b0;
            bus.b_rvalid <= 1'b0;
        end else begin
            bus.a_rvalid <= a_acc;
            bus.b_rvalid <= b_acc;
            if (a_acc) bus.a_rdata <= (RD_MODE != 0) ? a_merged : a_old;
            if (b_acc) bus.b_rdata <= (RD_MODE != 0) ? b_merged : b_old;
        end
    end
endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench: dut0 is read-first with clear, dut1 is write-first without
// clear; both see the same port stimulus.
module tb_ram_dp_be;
    localparam int WIDTH = 32;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy0, busy1;
    int   vectors = 0;
    int   miscompares = 0;
    int   n_busy, n_rv;

    always #5 clk = ~clk;

    ram_dp_be_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYTE_W(8)) if0 ();
    ram_dp_be_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYTE_W(8)) if1 ();

    assign if1.a_en = if0.a_en;   assign if1.b_en = if0.b_en;
    assign if1.a_we = if0.a_we;   assign if1.b_we = if0.b_we;
    assign if1.a_be = if0.a_be;   assign if1.b_be = if0.b_be;
    assign if1.a_addr = if0.a_addr;   assign if1.b_addr = if0.b_addr;
    assign if1.a_wdata = if0.a_wdata; assign if1.b_wdata = if0.b_wdata;

    ram_dp_be #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYTE_W(8), .RD_MODE(0), .INIT_CLEAR(1)) dut0 (
        .clk(clk), .rst(rst), .init_busy(busy0), .bus(if0.slave));
    ram_dp_be #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYTE_W(8), .RD_MODE(1), .INIT_CLEAR(0)) dut1 (
        .clk(clk), .rst(rst), .init_busy(busy1), .bus(if1.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic port_a(input logic en, input logic we, input logic [3:0] be,
                          input logic [7:0] addr, input logic [31:0] wdata);
        if0.a_en = en; if0.a_we = we; if0.a_be = be; if0.a_addr = addr; if0.a_wdata = wdata;
    endtask

    task automatic port_b(input logic en, input logic we, input logic [3:0] be,
                          input logic [7:0] addr, input logic [31:0] wdata);
        if0.b_en = en; if0.b_we = we; if0.b_be = be; if0.b_addr = addr; if0.b_wdata = wdata;
    endtask

    task automatic idle();
        port_a(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        port_b(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    endtask

    // Counts edges until dut0 drops init_busy, and rvalid pulses seen meanwhile.
    task automatic wait_clear(output int edges, output int rv);
        edges = 0;
        rv    = 0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            edges++;
            rv += int'(if0.a_rvalid) + int'(if0.b_rvalid);
            if (!busy0) break;
        end
    endtask

    initial begin
        idle();
        tick(); tick();
        check("reset_a_rdata",  if0.a_rdata, 32'h0);
        check("reset_b_rdata",  if0.b_rdata, 32'h0);
        check("reset_rvalid",   {30'h0, if0.a_rvalid, if0.b_rvalid}, 32'h0);
        check("reset_busy0",    {31'h0, busy0}, 32'h1);
        check("reset_busy1",    {31'h0, busy1}, 32'h0);

        rst = 1'b0;
        wait_clear(n_busy, n_rv);
        check("clear_cycles", n_busy, 256);

        // Byte enables
        port_a(1, 1, 4'hF, 8'h10, 32'h11223344); tick();
        port_a(1, 1, 4'h5, 8'h10, 32'hAABBCCDD); tick();
        port_a(1, 0, 4'h0, 8'h10, 32'h0);        tick();
        check("be_rdata",  if0.a_rdata, 32'h11BB33DD);
        check("be_rvalid", {31'h0, if0.a_rvalid}, 32'h1);
        idle(); tick();
        check("idle_rvalid", {31'h0, if0.a_rvalid}, 32'h0);
        check("idle_hold",   if0.a_rdata, 32'h11BB33DD);
        port_a(1, 1, 4'h0, 8'h10, 32'hFFFFFFFF); tick();
        check("be0_rvalid", {31'h0, if0.a_rvalid}, 32'h1);
        port_a(1, 0, 4'h0, 8'h10, 32'h0); tick();
        check("be0_nowrite", if0.a_rdata, 32'h11BB33DD);

        // Same-port read-during-write
        port_a(1, 1, 4'hF, 8'h20, 32'h01010101); tick();
        port_a(1, 1, 4'hF, 8'h20, 32'h02020202); tick();
        check("rdw_read_first",  if0.a_rdata, 32'h01010101);
        check("rdw_write_first", if1.a_rdata, 32'h02020202);
        port_a(1, 1, 4'h3, 8'h20, 32'h03030303); tick();
        check("rdw_rf_partial", if0.a_rdata, 32'h02020202);
        check("rdw_wf_merged",  if1.a_rdata, 32'h02020303);

        // Dual-write collision on a cleared word
        port_a(1, 1, 4'h3, 8'h30, 32'hAAAAAAAA);
        port_b(1, 1, 4'h6, 8'h30, 32'hBBBBBBBB); tick();
        idle();
        port_a(1, 0, 4'h0, 8'h30, 32'h0); tick();
        check("collision", if0.a_rdata, 32'h00BBAAAA);

        // Cross-port read during write
        port_a(1, 1, 4'hF, 8'h40, 32'h00000055);
        port_b(1, 0, 4'h0, 8'h40, 32'h0); tick();
        check("xport_old",    if0.b_rdata, 32'h0);
        check("xport_rvalid", {31'h0, if0.b_rvalid}, 32'h1);
        idle();
        port_b(1, 0, 4'h0, 8'h40, 32'h0); tick();
        check("xport_new", if0.b_rdata, 32'h00000055);

        // Garbage followed by a reset-triggered clear
        idle();
        port_a(1, 1, 4'hF, 8'h05, 32'hDEADBEEF); tick();
        port_a(1, 0, 4'h0, 8'h05, 32'h0);        tick();
        check("garbage_written", if0.a_rdata, 32'hDEADBEEF);
        idle();
        rst = 1'b1; tick();
        check("rst_rdata",  if0.a_rdata, 32'h0);
        check("rst_rvalid", {31'h0, if0.a_rvalid}, 32'h0);
        rst = 1'b0;
        wait_clear(n_busy, n_rv);
        check("reclear_cycles", n_busy, 256);
        port_a(1, 0, 4'h0, 8'h05, 32'h0); tick();
        check("cleared_05", if0.a_rdata, 32'h0);
        check("cleared_05_rvalid", {31'h0, if0.a_rvalid}, 32'h1);

        // Reset mid-clear with requests held during busy
        idle();
        rst = 1'b1; tick();
        rst = 1'b0;
        port_a(1, 0, 4'h0, 8'h05, 32'h0);
        port_b(1, 0, 4'h0, 8'h10, 32'h0);
        n_rv = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            n_rv += int'(if0.a_rvalid) + int'(if0.b_rvalid);
        end
        check("midclear_busy", {31'h0, busy0}, 32'h1);
        check("midclear_no_rvalid", n_rv, 0);
        rst = 1'b1; tick();
        check("midrst_rdata",  if0.a_rdata, 32'h0);
        check("midrst_rvalid", {31'h0, if0.b_rvalid}, 32'h0);
        rst = 1'b0;
        wait_clear(n_busy, n_rv);
        check("restart_cycles", n_busy, 256);
        check("busy_no_rvalid", n_rv, 0);
        tick();
        check("first_access_rvalid", {31'h0, if0.a_rvalid}, 32'h1);
        check("first_access_rdata",  if0.b_rdata, 32'h0);

        idle(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
